// File: rtl/ascon_ctrl_fsm_param.sv
// Ascon AEAD sequencing controller (Moore FSM) driving the round datapath.
// Phases: IDLE -> INIT -> (WAIT_AD/AD)* -> (WAIT_TXT/TXT)* -> WAIT_FIN -> FINAL.
// Owns its round and block counters; run-time AD/text block counts.
// Optional build macro ASCON_CTRL_ABORT_EN adds abort_i (return to IDLE).
module ascon_ctrl_fsm_param #(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6,
  parameter int unsigned BLK_W    = 4
) (
  input  logic             clock_i,
  input  logic             resetb_i,
`ifdef ASCON_CTRL_ABORT_EN
  input  logic             abort_i,
`endif
  input  logic             start_i,
  input  logic [BLK_W-1:0] nb_ad_i,
  input  logic [BLK_W-1:0] nb_txt_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic             en_reg_data_o,
  output logic             input_mode_o,
  output logic             en_reg_state_o,
  output logic [3:0]       round_o,
  output logic [BLK_W-1:0] bloc_o,
  output logic [1:0]       bypass_xor_begin_o,
  output logic [1:0]       bypass_xor_end_o,
  output logic             dom_sep_o,
  output logic             en_reg_cipher_o,
  output logic             cipher_valid_o,
  output logic             en_reg_tag_o,
  output logic             end_init_o,
  output logic             end_associate_o,
  output logic             end_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    IDLE, INIT, WAIT_AD, AD, WAIT_TXT, TXT, WAIT_FIN, FINAL
  } state_t;

  localparam logic [3:0] LAST_A = 4'(ROUNDS_A - 1);
  localparam logic [3:0] LAST_B = 4'(ROUNDS_B - 1);
  localparam logic [BLK_W-1:0] ONE_BLK = BLK_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       round_q, round_d;
  logic [BLK_W-1:0] bloc_q, bloc_d;
  logic [BLK_W-1:0] nb_ad_q, nb_ad_d;
  logic [BLK_W-1:0] nb_txt_q, nb_txt_d;
  logic             cipher_valid_q;
  logic [BLK_W-1:0] bloc_inc;
  logic             first_round;

  assign bloc_inc    = bloc_q + ONE_BLK;
  assign first_round = (round_q == '0);

  // State, counters, latched block counts and the delayed cipher strobe
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q        <= IDLE;
      round_q        <= '0;
      bloc_q         <= '0;
      nb_ad_q        <= '0;
      nb_txt_q       <= '0;
      cipher_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      round_q        <= round_d;
      bloc_q         <= bloc_d;
      nb_ad_q        <= nb_ad_d;
      nb_txt_q       <= nb_txt_d;
      cipher_valid_q <= en_reg_cipher_o;
    end
  end

  // Next-state, counter update and Moore output decode
  always_comb begin
    state_d            = state_q;
    round_d            = '0;
    bloc_d             = bloc_q;
    nb_ad_d            = nb_ad_q;
    nb_txt_d           = nb_txt_q;
    data_ready_o       = 1'b0;
    input_mode_o       = 1'b0;
    en_reg_state_o     = 1'b0;
    bypass_xor_begin_o = 2'b00;
    bypass_xor_end_o   = 2'b00;
    dom_sep_o          = 1'b0;
    en_reg_cipher_o    = 1'b0;
    en_reg_tag_o       = 1'b0;
    end_init_o         = 1'b0;
    end_associate_o    = 1'b0;
    end_o              = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = INIT;
          nb_ad_d  = nb_ad_i;
          nb_txt_d = (nb_txt_i == '0) ? ONE_BLK : nb_txt_i;
          bloc_d   = '0;
        end
      end

      INIT: begin
        en_reg_state_o = 1'b1;
        input_mode_o   = first_round;
        if (round_q == LAST_A) begin
          bypass_xor_end_o = 2'b01;
          end_init_o       = 1'b1;
          // With no AD the domain separation lands at the end of init
          if (nb_ad_q == '0) begin
            dom_sep_o       = 1'b1;
            end_associate_o = 1'b1;
            state_d         = WAIT_TXT;
          end else begin
            state_d = WAIT_AD;
          end
        end else begin
          round_d = round_q + 4'd1;
        end
      end

      WAIT_AD: begin
        data_ready_o = 1'b1;
        if (data_valid_i) state_d = AD;
      end

      AD: begin
        en_reg_state_o = 1'b1;
        if (first_round) bypass_xor_begin_o = 2'b01;
        if (round_q == LAST_B) begin
          if (bloc_inc == nb_ad_q) begin
            dom_sep_o       = 1'b1;
            end_associate_o = 1'b1;
            bloc_d          = '0;
            state_d         = WAIT_TXT;
          end else begin
            bloc_d  = bloc_inc;
            state_d = WAIT_AD;
          end
        end else begin
          round_d = round_q + 4'd1;
        end
      end

      WAIT_TXT: begin
        data_ready_o = 1'b1;
        // A single text block goes straight to FINAL
        if (data_valid_i) state_d = (nb_txt_q == ONE_BLK) ? FINAL : TXT;
      end

      TXT: begin
        en_reg_state_o = 1'b1;
        if (first_round) begin
          bypass_xor_begin_o = 2'b01;
          en_reg_cipher_o    = 1'b1;
        end
        if (round_q == LAST_B) begin
          bloc_d  = bloc_inc;
          state_d = (bloc_inc == (nb_txt_q - ONE_BLK)) ? WAIT_FIN : WAIT_TXT;
        end else begin
          round_d = round_q + 4'd1;
        end
      end

      WAIT_FIN: begin
        data_ready_o = 1'b1;
        if (data_valid_i) state_d = FINAL;
      end

      FINAL: begin
        en_reg_state_o = 1'b1;
        if (first_round) begin
          bypass_xor_begin_o = 2'b10;
          en_reg_cipher_o    = 1'b1;
        end
        if (round_q == LAST_A) begin
          bypass_xor_end_o = 2'b11;
          en_reg_tag_o     = 1'b1;
          end_o            = 1'b1;
          bloc_d           = '0;
          state_d          = IDLE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef ASCON_CTRL_ABORT_EN
    // Abort overrides every transition; this cycle's enables are left intact
    if (abort_i && (state_q != IDLE)) begin
      state_d  = IDLE;
      round_d  = '0;
      bloc_d   = '0;
      nb_ad_d  = '0;
      nb_txt_d = '0;
    end
`endif
  end

  assign en_reg_data_o  = data_ready_o & data_valid_i;
  assign round_o        = round_q;
  assign bloc_o         = bloc_q;
  assign cipher_valid_o = cipher_valid_q;
  assign busy_o         = (state_q != IDLE);

endmodule
